// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Main control FSM for the multicycle MIPS datapath. It steps each
// instruction through fetch, decode, execute, memory and writeback states,
// chosen by the IR opcode, and drives every datapath enable and mux select.
// Its ALU_op output feeds ALU_Control. Memory accesses wait on MemReady, so
// the FSM stalls for as long as memory is slow.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   Opcode       IR[31:26], looked at only in DECODE
//   MemReady     memory finishes the current access this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU Zero (beq)
//   IorD         memory address select: 0=PC, 1=ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      instruction register load
//   MemtoReg     register write data select: 0=ALUOut, 1=MDR
//   RegDst       destination register select: 0=rt, 1=rd
//   RegWrite     register file write enable
//   ALUSrcA      ALU A select: 0=PC, 1=A
//   ALUSrcB      ALU B select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
//   ALU_op       to ALU_Control: 00=add, 01=sub, 10=use FuncCode
//   PCSource     PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   State        current state encoding, for debug
//   IllegalOp    one-cycle pulse in DECODE on an unsupported opcode
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_op,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RCOMP  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;

    // Moore part of the control word. IRWrite, the FETCH half of PCWrite and
    // IllegalOp depend on inputs and are formed outside the register.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl_q;
    logic [5:0] op_latched;
    logic       op_supported;

    // Control word for a given state. The register is loaded with the word
    // for the state being entered, so the outputs are registered yet still
    // line up with State in the same cycle.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.ior_d     = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RCOMP: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Flags whether the opcode on the port is one this FSM knows how to run.
    // Only meaningful while in DECODE, where it gates IllegalOp.
    always_comb begin
        op_supported = (Opcode == OP_RTYPE) || (Opcode == OP_LW)  ||
                       (Opcode == OP_SW)    || (Opcode == OP_BEQ) ||
                       (Opcode == OP_J)     || (Opcode == OP_ADDI);
    end

    // Next-state selection. FETCH, MEMRD and MEMWR hold until MemReady.
    // MEMADR picks load versus store from the opcode captured in DECODE, so
    // the IR port may change freely afterwards. Unused encodings recover to
    // FETCH.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH:  if (MemReady) next_state = DECODE;
            DECODE: begin
                if ((Opcode == OP_LW) || (Opcode == OP_SW))
                    next_state = MEMADR;
                else if (Opcode == OP_RTYPE)
                    next_state = EXEC;
                else if (Opcode == OP_BEQ)
                    next_state = BRANCH;
                else if (Opcode == OP_J)
                    next_state = JUMP;
                else if (Opcode == OP_ADDI)
                    next_state = ADDIEX;
                else
                    next_state = FETCH;
            end
            MEMADR: next_state = (op_latched == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (MemReady) next_state = MEMWB;
            MEMWB:  next_state = FETCH;
            MEMWR:  if (MemReady) next_state = FETCH;
            EXEC:   next_state = RCOMP;
            RCOMP:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            JUMP:   next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // State, registered control word and the opcode latch. Reset clears the
    // control word along with the state, so any memory request in flight
    // drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ctrl_q     <= '0;
            op_latched <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= decode_ctrl(next_state);
            if (state == DECODE)
                op_latched <= Opcode;
        end
    end

    // FETCH loads IR and PC only in the cycle memory delivers the word.
    // JUMP contributes its unconditional PC load through the register.
    assign IRWrite     = (state == FETCH) && MemReady;
    assign PCWrite     = ctrl_q.pc_write || ((state == FETCH) && MemReady);
    assign IllegalOp   = (state == DECODE) && !op_supported;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.ior_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALU_op      = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign State       = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Self-checking bench for mips_multicycle_control. Each instruction is
// described as a route of named steps derived from its opcode. Every cycle,
// the stimulus side drives Opcode/MemReady and queues the outputs expected
// for that step. A separate monitor samples the DUT on the falling edge and
// compares it against the queue.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Step numbers follow the published state encodings.
    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3;
    localparam int ST_MEMRD = 4, ST_MEMWB = 5, ST_MEMWR = 6, ST_EXEC = 7;
    localparam int ST_RCOMP = 8, ST_BRANCH = 9, ST_JUMP = 10;
    localparam int ST_ADDIEX = 11, ST_ADDIWB = 12;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALU_op, PCSource;
    logic [3:0] State;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    passed;
    logic [5:0] legal_ops [6];

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_op(ALU_op),
        .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one step, straight from the per-state output table.
    function automatic obs_t model_outputs(input int step, input logic mem_ready,
                                           input logic illegal);
        obs_t o;
        o = '0;
        o.state = step[3:0];
        case (step)
            ST_FETCH: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'b01;
                o.ir_write = mem_ready; o.pc_write = mem_ready;
            end
            ST_DECODE: begin o.alu_src_b = 2'b11; o.illegal_op = illegal; end
            ST_MEMADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ST_MEMRD:  begin o.mem_read = 1'b1; o.ior_d = 1'b1; end
            ST_MEMWB:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            ST_MEMWR:  begin o.mem_write = 1'b1; o.ior_d = 1'b1; end
            ST_EXEC:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            ST_RCOMP:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            ST_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                o.pc_write_cond = 1'b1; o.pc_source = 2'b01;
            end
            ST_JUMP:   begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
            ST_ADDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            ST_ADDIWB: begin o.reg_write = 1'b1; end
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // One cycle of stimulus: drive the inputs just after the rising edge and
    // queue what the DUT must show for this step.
    task automatic applyStimulus(input int step, input string nm,
                                 input logic [5:0] op, input logic mr,
                                 input logic ill);
        @(posedge clk);
        #1;
        Opcode   = op;
        MemReady = mr;
        exp_q.push_back(model_outputs(step, mr, ill));
        name_q.push_back(nm);
    endtask

    // Hold reset for a number of cycles, then release it. Every one of those
    // cycles, including the one in which rst_n rises, must read as IDLE.
    task automatic resetSequence(input int hold_cycles);
        for (int c = 0; c < hold_cycles; c++) begin
            @(posedge clk);
            #1;
            rst_n    = 1'b0;
            MemReady = 1'(($urandom));
            exp_q.push_back(model_outputs(ST_IDLE, 1'b0, 1'b0));
            name_q.push_back("reset_hold");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(model_outputs(ST_IDLE, 1'b0, 1'b0));
        name_q.push_back("reset_release");
    endtask

    // Run one instruction from FETCH. fetch_stall/mem_stall are the number of
    // MemReady-low cycles before the access completes. abort_at >= 0 pulls
    // reset in that MEMRD cycle instead of finishing the load.
    task automatic runInstr(input logic [5:0] op, input int fetch_stall,
                            input int mem_stall, input int abort_at);
        int route[$];
        logic ill;
        ill = !is_legal(op);
        for (int i = 0; i <= fetch_stall; i++)
            applyStimulus(ST_FETCH, "fetch", 6'($urandom), (i == fetch_stall), 1'b0);
        applyStimulus(ST_DECODE, "decode", op, 1'($urandom), ill);
        if (op == OP_LW)          route = '{ST_MEMADR, ST_MEMRD, ST_MEMWB};
        else if (op == OP_SW)     route = '{ST_MEMADR, ST_MEMWR};
        else if (op == OP_RTYPE)  route = '{ST_EXEC, ST_RCOMP};
        else if (op == OP_BEQ)    route = '{ST_BRANCH};
        else if (op == OP_J)      route = '{ST_JUMP};
        else if (op == OP_ADDI)   route = '{ST_ADDIEX, ST_ADDIWB};
        else                      route = {};
        foreach (route[k]) begin
            if (route[k] == ST_MEMRD || route[k] == ST_MEMWR) begin
                for (int i = 0; i <= mem_stall; i++) begin
                    if (route[k] == ST_MEMRD && i == abort_at) begin
                        resetSequence(1);
                        return;
                    end
                    applyStimulus(route[k], (route[k] == ST_MEMRD) ? "memrd" : "memwr",
                                  6'($urandom), (i == mem_stall), 1'b0);
                end
            end else begin
                applyStimulus(route[k], "step", 6'($urandom), 1'($urandom), 1'b0);
            end
        end
    endtask

    task automatic checkOutput(input obs_t act, input obs_t exp, input string nm);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s (state %0d): got %h required %h", nm, exp.state, act, exp);
        end
    endtask

    // Monitor: each falling edge, if a step is pending, sample and compare.
    initial begin
        obs_t act;
        obs_t exp;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = '{State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                        ALUSrcB, ALU_op, PCSource, IllegalOp};
                checkOutput(act, exp, nm);
            end
        end
    end

    // Directed scenarios first, then a randomized instruction stream.
    initial begin
        logic [5:0] op;
        int fs, ms, ab;
        checks   = 0;
        passed   = 0;
        rst_n    = 1'b0;
        Opcode   = '0;
        MemReady = 1'b0;
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

        resetSequence(3);
        runInstr(OP_RTYPE, 0, 0, -1);
        runInstr(OP_LW, 0, 3, -1);
        runInstr(OP_SW, 0, 2, -1);
        runInstr(OP_BEQ, 0, 0, -1);
        runInstr(OP_J, 0, 0, -1);
        runInstr(6'b111111, 0, 0, -1);
        runInstr(OP_ADDI, 3, 0, -1);
        runInstr(OP_LW, 1, 4, 2);
        runInstr(OP_RTYPE, 0, 0, -1);

        for (int n = 0; n < 300; n++) begin
            int pick;
            pick = int'($urandom_range(0, 7));
            if (pick < 6) op = legal_ops[pick];
            else          op = 6'($urandom);
            fs = int'($urandom_range(0, 3));
            ms = int'($urandom_range(0, 3));
            ab = -1;
            if (op == OP_LW && $urandom_range(0, 9) == 0)
                ab = int'($urandom_range(0, ms));
            runInstr(op, fs, ms, ab);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
